edge_detector_array: RTL and testbench
======================================

# edge_detector_array

Multi-channel, parametrised edge detector replacing the single-channel falling-edge FSM. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable qualification length, and reports rising, falling or both edges per a per-channel runtime mode. Outputs are one-cycle event pulses, sticky pending flags with per-channel clear, and a combined interrupt. It sits between board-level inputs (buttons, external strobes) and the control FSMs / interrupt logic.

## Interface

- `CHANNELS`, 4: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `FILTER_LEN`, 4: consecutive identical synchronised samples required to accept a level change (≥1).
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in` in CHANNELS: asynchronous raw inputs.
- `mode` in 2*CHANNELS: per channel `mode[2i+1:2i]`. 00 off, 01 rising, 10 falling, 11 both.
- `clr` in CHANNELS: per-channel pending clear, level-sensitive, synchronous.
- `level` out CHANNELS: filtered, debounced level.
- `pulse` out CHANNELS: one-cycle pulse per accepted enabled edge.
- `pending` out CHANNELS: sticky event flags.
- `irq` out 1: OR of `pending`.

## Operation

- Per channel, `s` is the last synchroniser stage.
- Channel FSM states:
  - IDLE_LOW: if `s`=1, go to QUAL_HIGH with cnt=1.
  - QUAL_HIGH: if `s`=0, return to IDLE_LOW (glitch rejected). Elif cnt=FILTER_LEN-1, go to IDLE_HIGH and accept a rising edge. Else cnt+1.
  - IDLE_HIGH / QUAL_LOW: mirror images for the falling direction.
- FILTER_LEN=1: IDLE states transition directly to the opposite IDLE state on a `s` change, accepting the edge in that cycle.
- cnt width is clog2(FILTER_LEN)+1. cnt clears on every IDLE entry.
- `level` is 1 in IDLE_HIGH and QUAL_LOW, and 0 otherwise.
- `pulse[i]` is registered high for exactly one cycle on an accepted edge whose direction is enabled by `mode[i]`, sampled in the accept cycle.
- Mode 00: the FSM and `level` still run; no pulse, no pending.
- `pending[i]` is set by `pulse[i]` and cleared by `clr[i]`. If set and clear coincide, set wins.
- `irq` is combinational `|pending`.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.

## Timing

- Reset values:
  - synchroniser flops 0, state IDLE_LOW, cnt 0
  - `level`, `pulse`, `pending`, `irq` all 0
- Reset mid-qualification abandons the pending edge with no pulse.
- Latency from the clock edge that first samples a new stable `in` level to `pulse` high: SYNC_STAGES+FILTER_LEN-1 further edges. Example: 2+4-1 = 5 edges.
- `level` changes on the same edge as `pulse`. `pending` sets on the same edge. `irq` follows in the same cycle.
- Input held high through reset release yields one rising edge after the nominal latency, because reset assumes low.
- Pulses widen or merge never: minimum spacing between accepted edges on one channel is FILTER_LEN cycles.
- `clr` takes effect on the next edge. `pending` reads 0 the cycle after `clr` unless a new pulse coincides.

## Structure

- Shared package `edge_det_pkg`:
  - state encodings IDLE_LOW/QUAL_HIGH/IDLE_HIGH/QUAL_LOW
  - mode constants MODE_OFF/RISE/FALL/BOTH
- Sub-module `edge_det_channel`: synchroniser, filter counter, FSM, pulse and pending for one channel. It is parametrised by SYNC_STAGES and FILTER_LEN.
- Top generates CHANNELS instances and the `irq` reduction.

## Test plan

- Reset, then `in[0]` 0→1 held, mode 01, defaults: `pulse[0]` high for one cycle exactly 5 edges after the sampling edge. `level[0]` rises on the same edge, and `pending[0]` and `irq` go to 1.
- 3-cycle high glitch on `in[1]`, FILTER_LEN=4, mode 11: no pulse, `level[1]` stays 0. A 4-cycle high is accepted.
- Mode 10 on ch2, full high-then-low pulse: only the falling edge produces `pulse[2]`. Mode 00 produces no pulse while `level[2]` still toggles.
- `clr[0]` asserted in the same cycle as a new `pulse[0]`: `pending[0]` remains 1. `clr[0]` alone clears it next cycle, and `irq` drops when all pending are 0.
- All 4 channels toggle simultaneously, mode 11: four pulses in the same cycle. Then `rst` asserted during qualification gives all outputs 0 and no pulse.
- FILTER_LEN=1, SYNC_STAGES=3: latency 3 edges, and toggling every 2 cycles yields a pulse for every edge.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared encodings for the multi-channel edge detector: channel FSM states and
// per-channel edge-mode selectors.
package edge_det_pkg;

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] QUAL_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] QUAL_LOW  = 2'd3;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_det_channel.sv
// One edge-detector channel: input synchroniser, glitch-qualification FSM,
// registered event pulse and sticky pending flag.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_in,
  input  logic [1:0] i_mode,
  input  logic       i_clr,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_pending
);

  localparam int unsigned    CW       = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_level;
  logic                   r_pulse;
  logic                   r_pending;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_level_nxt;
  logic                   w_pulse_nxt;
  logic                   w_pending_nxt;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_pulse   <= w_pulse_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Qualification: a level change is accepted after FILTER_LEN identical samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        w_cnt_nxt = '0;
        if (w_s) begin
          if (FILTER_LEN == 1) begin
            w_state_nxt = IDLE_HIGH;
            w_rise      = 1'b1;
          end else begin
            w_state_nxt = QUAL_HIGH;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      QUAL_HIGH: begin
        if (!w_s) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_rise      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        w_cnt_nxt = '0;
        if (!w_s) begin
          if (FILTER_LEN == 1) begin
            w_state_nxt = IDLE_LOW;
            w_fall      = 1'b1;
          end else begin
            w_state_nxt = QUAL_LOW;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      default: begin
        if (w_s) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_fall      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    endcase
  end

  // Outputs follow the next state so level, pulse and pending move together.
  always_comb begin
    w_level_nxt   = (w_state_nxt == IDLE_HIGH) || (w_state_nxt == QUAL_LOW);
    w_pulse_nxt   = (w_rise && ((i_mode == MODE_RISE) || (i_mode == MODE_BOTH))) ||
                    (w_fall && ((i_mode == MODE_FALL) || (i_mode == MODE_BOTH)));
    w_pending_nxt = w_pulse_nxt || (r_pending && !i_clr);
  end

  assign o_level   = r_level;
  assign o_pulse   = r_pulse;
  assign o_pending = r_pending;

endmodule

// File: rtl/edge_detector_array.sv
// Multi-channel edge detector: independent debounced channels with per-channel
// edge mode, event pulses, sticky pending flags and a combined interrupt.
module edge_detector_array
  import edge_det_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_in     (in[g]),
      .i_mode   (mode[2*g+1:2*g]),
      .i_clr    (clr[g]),
      .o_level  (level[g]),
      .o_pulse  (pulse[g]),
      .o_pending(pending[g])
    );
  end

  // Interrupt tracks the pending flags within the same cycle.
  assign irq = |pending;

endmodule

// File: tb/tb_edge_detector_array.sv
// Scoreboard bench for edge_detector_array: default 4-channel build plus a
// single-channel SYNC_STAGES=3 / FILTER_LEN=1 build.
module tb_edge_detector_array;

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] v;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_v, clr_v, level_v, pulse_v, pending_v;
  logic [7:0] mode_v;
  logic       irq_v;
  logic [0:0] in1_v, clr1_v, level1_v, pulse1_v, pending1_v;
  logic [1:0] mode1_v;
  logic       irq1_v;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  string sel_name[7] = '{"pulse", "level", "pending", "irq", "pulse1", "level1", "pend_irq1"};

  always #5 clk = ~clk;

  edge_detector_array #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .in(in_v), .mode(mode_v), .clr(clr_v),
    .level(level_v), .pulse(pulse_v), .pending(pending_v), .irq(irq_v)
  );

  edge_detector_array #(.CHANNELS(1), .SYNC_STAGES(3), .FILTER_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1_v), .mode(mode1_v), .clr(clr1_v),
    .level(level1_v), .pulse(pulse1_v), .pending(pending1_v), .irq(irq1_v)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      0:       return pulse_v;
      1:       return level_v;
      2:       return pending_v;
      3:       return {3'b000, irq_v};
      4:       return {3'b000, pulse1_v};
      5:       return {3'b000, level1_v};
      6:       return {2'b00, irq1_v, pending1_v};
      default: return 4'b0000;
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input logic [3:0] v, input string tag);
    exp_t e;
    int   i;
    e.cyc = c; e.sel = sel; e.v = v; e.tag = tag;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic expect_span(input int c0, input int c1, input int sel, input logic [3:0] v,
                             input string tag);
    for (int c = c0; c <= c1; c++) expect_at(c, sel, v, tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare due expectations shortly after each active edge.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #2;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_eq($sformatf("%s.%s", e.tag, sel_name[e.sel]), 32'(observe(e.sel)), 32'(e.v));
    end
  end

  initial begin
    int t;
    rst = 1'b1; in_v = '0; clr_v = '0; mode_v = 8'b11_10_11_01;
    in1_v = '0; clr1_v = '0; mode1_v = 2'b11;
    tick(1);
    t = cyc;
    for (int s = 0; s < 7; s++) expect_at(t + 1, s, 4'b0000, "reset");
    tick(1);
    rst = 1'b0;
    tick(2);

    // ch0 rising, mode rise
    t = cyc;
    expect_at(t + 5, 0, 4'b0000, "s1_early");
    expect_at(t + 5, 1, 4'b0000, "s1_early");
    expect_at(t + 5, 3, 4'b0000, "s1_early");
    expect_at(t + 6, 0, 4'b0001, "s1_pulse");
    expect_at(t + 6, 1, 4'b0001, "s1_pulse");
    expect_at(t + 6, 2, 4'b0001, "s1_pulse");
    expect_at(t + 6, 3, 4'b0001, "s1_pulse");
    expect_at(t + 7, 0, 4'b0000, "s1_one");
    expect_at(t + 7, 1, 4'b0001, "s1_one");
    in_v[0] = 1'b1;
    tick(8);

    // ch1 3-cycle glitch rejected
    t = cyc;
    expect_span(t + 1, t + 9, 0, 4'b0000, "s2_glitch");
    expect_span(t + 1, t + 9, 1, 4'b0001, "s2_glitch");
    in_v[1] = 1'b1;
    tick(3);
    in_v[1] = 1'b0;
    tick(10);

    // ch1 4-cycle high accepted both ways
    t = cyc;
    expect_at(t + 5, 0, 4'b0000, "s2_acc");
    expect_at(t + 6, 0, 4'b0010, "s2_rise");
    expect_at(t + 6, 1, 4'b0011, "s2_rise");
    expect_at(t + 6, 2, 4'b0011, "s2_rise");
    expect_at(t + 7, 0, 4'b0000, "s2_rise1");
    expect_at(t + 9, 1, 4'b0011, "s2_hold");
    expect_at(t + 10, 0, 4'b0010, "s2_fall");
    expect_at(t + 10, 1, 4'b0001, "s2_fall");
    expect_at(t + 11, 0, 4'b0000, "s2_fall1");
    in_v[1] = 1'b1;
    tick(4);
    in_v[1] = 1'b0;
    tick(8);

    // ch2 mode fall: only the falling edge pulses
    t = cyc;
    expect_span(t + 1, t + 11, 0, 4'b0000, "s3_norise");
    expect_at(t + 6, 1, 4'b0101, "s3_lvl");
    expect_at(t + 7, 2, 4'b0011, "s3_nopend");
    expect_at(t + 12, 0, 4'b0100, "s3_fall");
    expect_at(t + 12, 1, 4'b0001, "s3_fall");
    expect_at(t + 12, 2, 4'b0111, "s3_fall");
    expect_at(t + 13, 0, 4'b0000, "s3_fall1");
    in_v[2] = 1'b1;
    tick(6);
    in_v[2] = 1'b0;
    tick(8);

    // ch2 mode off: level toggles, no events
    t = cyc;
    expect_span(t + 1, t + 14, 0, 4'b0000, "s3_off");
    expect_at(t + 6, 1, 4'b0101, "s3_off_lvl");
    expect_at(t + 12, 1, 4'b0001, "s3_off_lvl");
    expect_at(t + 13, 2, 4'b0111, "s3_off_pend");
    mode_v[5:4] = 2'b00;
    in_v[2] = 1'b1;
    tick(6);
    in_v[2] = 1'b0;
    tick(9);
    mode_v[5:4] = 2'b10;

    // ch0 falls silently, then rises with a coincident clear
    t = cyc;
    expect_at(t + 6, 0, 4'b0000, "s4_fall");
    expect_at(t + 6, 1, 4'b0000, "s4_fall");
    in_v[0] = 1'b0;
    tick(8);
    t = cyc;
    expect_at(t + 6, 0, 4'b0001, "s4_setclr");
    expect_at(t + 6, 1, 4'b0001, "s4_setclr");
    expect_at(t + 6, 2, 4'b0111, "s4_setclr");
    expect_at(t + 9, 2, 4'b0110, "s4_clr0");
    expect_at(t + 9, 3, 4'b0001, "s4_clr0");
    expect_at(t + 10, 3, 4'b0001, "s4_irq");
    expect_at(t + 11, 2, 4'b0000, "s4_clrall");
    expect_at(t + 11, 3, 4'b0000, "s4_clrall");
    in_v[0] = 1'b1;
    tick(5);
    clr_v = 4'b0001;
    tick(1);
    clr_v = 4'b0000;
    tick(2);
    clr_v = 4'b0001;
    tick(1);
    clr_v = 4'b0000;
    tick(1);
    clr_v = 4'b1111;
    tick(1);
    clr_v = 4'b0000;
    tick(2);

    // all channels toggle together, mode both
    t = cyc;
    expect_at(t + 5, 0, 4'b0000, "s5_all");
    expect_at(t + 6, 0, 4'b1111, "s5_all");
    expect_at(t + 6, 1, 4'b1110, "s5_all");
    expect_at(t + 6, 2, 4'b1111, "s5_all");
    expect_at(t + 6, 3, 4'b0001, "s5_all");
    expect_at(t + 7, 0, 4'b0000, "s5_all1");
    expect_at(t + 10, 2, 4'b0000, "s5_clr");
    mode_v = 8'hFF;
    in_v = 4'b1110;
    tick(8);
    clr_v = 4'hF;
    tick(1);
    clr_v = 4'h0;
    tick(2);

    // reset during qualification abandons every edge
    t = cyc;
    expect_span(t + 1, t + 4, 0, 4'b0000, "s5_qual");
    expect_at(t + 4, 1, 4'b1110, "s5_qual");
    expect_span(t + 5, t + 11, 0, 4'b0000, "s5_rst");
    expect_span(t + 5, t + 11, 1, 4'b0000, "s5_rst");
    expect_span(t + 5, t + 11, 2, 4'b0000, "s5_rst");
    expect_span(t + 5, t + 11, 3, 4'b0000, "s5_rst");
    expect_at(t + 12, 0, 4'b0001, "s5_held");
    expect_at(t + 12, 1, 4'b0001, "s5_held");
    expect_at(t + 12, 2, 4'b0001, "s5_held");
    expect_at(t + 13, 0, 4'b0000, "s5_held1");
    in_v = 4'b0001;
    tick(4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);

    // FILTER_LEN=1, SYNC_STAGES=3: every 2-cycle toggle accepted
    t = cyc;
    expect_at(t + 3, 4, 4'b0000, "s6_lat");
    expect_at(t + 4, 6, 4'b0011, "s6_pend");
    for (int k = 0; k < 5; k++) begin
      expect_at(t + 4 + 2 * k, 4, 4'b0001, "s6_pulse");
      expect_at(t + 5 + 2 * k, 4, 4'b0000, "s6_gap");
      expect_at(t + 4 + 2 * k, 5, (k % 2 == 0) ? 4'b0001 : 4'b0000, "s6_lvl");
      expect_at(t + 5 + 2 * k, 5, (k % 2 == 0) ? 4'b0001 : 4'b0000, "s6_lvl");
    end
    for (int k = 0; k < 5; k++) begin
      in1_v = (k % 2 == 0) ? 1'b1 : 1'b0;
      tick(2);
    end
    tick(8);

    for (int w = 0; w < 50 && sb.size() > 0; w++) tick(1);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
